// File: rtl/denise_bus_ctrl_if.sv
// Register-bus signal bundle between the Amiga-side bus sequencer and its surroundings.
// slave = sequencer view, master = environment (synchronisers, register file) view.
interface denise_bus_ctrl_if;
  logic        cck;
  logic        cdac_r;
  logic        cdac_f;
  logic [7:0]  rga;
  logic [15:0] db_in;
  logic [15:0] rd_data;
  logic        reg_wr;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        rd_req;
  logic [15:0] db_out;
  logic        db_oen;
  logic        locked;

  modport slave (
    input  cck, cdac_r, cdac_f, rga, db_in, rd_data,
    output reg_wr, reg_addr, reg_wdata, rd_req, db_out, db_oen, locked
  );

  modport master (
    output cck, cdac_r, cdac_f, rga, db_in, rd_data,
    input  reg_wr, reg_addr, reg_wdata, rd_req, db_out, db_oen, locked
  );
endinterface

// File: rtl/denise_bus_ctrl.sv
// Denise register-bus cycle sequencer: CCK phase tracking, write forwarding, read sequencing.
// Optional: define DENISE_BUS_ECS_ID_EN to answer DENISEID ($07C) reads on DB.
module denise_bus_ctrl #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [7:0]  NOP_ADDR = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  denise_bus_ctrl_if.slave   bus
);

  localparam logic [7:0] TmoLim     = 8'(TIMEOUT);
  localparam logic [7:0] ClxdatAddr = 8'h07;  // $00E
  localparam logic [7:0] DenIdAddr  = 8'h3E;  // $07C

  typedef enum logic [2:0] {StIdle, StAddr, StWrWait, StRdReq, StRdDrive} state_e;

  state_e      state_q, state_d;
  logic [1:0]  ph_q, ph_d;
  logic        cck_prev_q, cck_prev_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        locked_q, locked_d;
  logic        reg_wr_q, reg_wr_d;
  logic        rd_req_q, rd_req_d;
  logic        db_oen_q, db_oen_d;
  logic [7:0]  reg_addr_q, reg_addr_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic [15:0] db_out_q, db_out_d;

  logic ev, cyc_start, tmo_hit, is_read, oen_kill;

  assign ev        = bus.cdac_r | bus.cdac_f;
  assign cyc_start = ev & bus.cck & ~cck_prev_q;

`ifdef DENISE_BUS_ECS_ID_EN
  assign is_read = (reg_addr_q == ClxdatAddr) || (reg_addr_q == DenIdAddr);
`else
  assign is_read = (reg_addr_q == ClxdatAddr);
`endif

  always_comb begin
    cck_prev_d = ev ? bus.cck : cck_prev_q;
    ph_d       = ph_q;
    if (cyc_start) begin
      ph_d = 2'd0;
    end else if (ev) begin
      ph_d = ph_q + 2'd1;
    end
    if (ev) begin
      tmo_d = 8'd0;
    end else if (tmo_q == 8'hFF) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 8'd1;
    end
    tmo_hit  = (tmo_d >= TmoLim);
    locked_d = locked_q;
    if (cyc_start) begin
      locked_d = 1'b1;
    end
    if (tmo_hit) begin
      locked_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    db_out_d    = db_out_q;
    db_oen_d    = db_oen_q;
    reg_wr_d    = 1'b0;
    rd_req_d    = 1'b0;
    if (tmo_hit) begin
      state_d  = StIdle;
      db_oen_d = 1'b0;
    end else if (cyc_start) begin
      // A new cycle start always wins; any access in flight is dropped.
      db_oen_d = 1'b0;
      if (locked_q) begin
        reg_addr_d = bus.rga;
        state_d    = StAddr;
      end else begin
        state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: ;
        StAddr: begin
          if (reg_addr_q == NOP_ADDR) begin
            state_d = StIdle;
          end else if (is_read) begin
            state_d  = StRdReq;
            rd_req_d = 1'b1;
          end else begin
            state_d = StWrWait;
          end
        end
        StWrWait: begin
          if (ev && ph_d == 2'd2) begin
            reg_wdata_d = bus.db_in;
            reg_wr_d    = 1'b1;
            state_d     = StIdle;
          end
        end
        StRdReq: begin
          // First clk carries the request; rd_data is valid on the second.
          if (!rd_req_q) begin
            db_out_d = bus.rd_data;
            db_oen_d = 1'b1;
            state_d  = StRdDrive;
          end
        end
        StRdDrive: begin
          if (ev && ph_d == 2'd3) begin
            db_oen_d = 1'b0;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Release DB combinationally in the strobe clk that ends or aborts the drive.
  assign oen_kill = cyc_start | ((state_q == StRdDrive) & ev & (ph_d == 2'd3));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ph_q        <= 2'd0;
      cck_prev_q  <= 1'b0;
      tmo_q       <= 8'd0;
      locked_q    <= 1'b0;
      reg_wr_q    <= 1'b0;
      rd_req_q    <= 1'b0;
      db_oen_q    <= 1'b0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 16'd0;
      db_out_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      cck_prev_q  <= cck_prev_d;
      tmo_q       <= tmo_d;
      locked_q    <= locked_d;
      reg_wr_q    <= reg_wr_d;
      rd_req_q    <= rd_req_d;
      db_oen_q    <= db_oen_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      db_out_q    <= db_out_d;
    end
  end

  assign bus.reg_wr    = reg_wr_q;
  assign bus.rd_req    = rd_req_q;
  assign bus.db_oen    = db_oen_q & ~oen_kill;
  assign bus.locked    = locked_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_wdata = reg_wdata_q;
  assign bus.db_out    = db_out_q;

endmodule
